// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_pkg.sv
// Shared source codes, FSM states and round-robin grant function for rrarb3.
// Source index doubles as the rotation pointer: grant search starts at last+1 mod 3.
package gf180mcu_fd_sc_mcu9t5v0__rrarb3_pkg;

  localparam logic [1:0] SRC_A    = 2'd0;
  localparam logic [1:0] SRC_B    = 2'd1;
  localparam logic [1:0] SRC_C    = 2'd2;
  localparam logic [1:0] SRC_NONE = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // One-hot grant {C,B,A}; last=3 never occurs but is treated like C so A leads.
  function automatic logic [2:0] rr_next(input logic [1:0] last, input logic [2:0] req);
    logic [2:0] g;
    g = 3'b000;
    case (last)
      SRC_A: begin
        if (req[1])      g = 3'b010;
        else if (req[2]) g = 3'b100;
        else if (req[0]) g = 3'b001;
      end
      SRC_B: begin
        if (req[2])      g = 3'b100;
        else if (req[0]) g = 3'b001;
        else if (req[1]) g = 3'b010;
      end
      default: begin
        if (req[0])      g = 3'b001;
        else if (req[1]) g = 3'b010;
        else if (req[2]) g = 3'b100;
      end
    endcase
    return g;
  endfunction

  function automatic logic [1:0] gnt_src(input logic [2:0] g);
    logic [1:0] s;
    s = SRC_NONE;
    if (g[0])      s = SRC_A;
    else if (g[1]) s = SRC_B;
    else if (g[2]) s = SRC_C;
    return s;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3_if.sv
// Three-producer request/ack lanes plus the shared valid/ready output port.
// master = producers and consumer side, slave = the arbiter.
interface gf180mcu_fd_sc_mcu9t5v0__rrarb3_if #(
  parameter int WIDTH = 8
);

  logic             req_a;
  logic             req_b;
  logic             req_c;
  logic [WIDTH-1:0] data_a;
  logic [WIDTH-1:0] data_b;
  logic [WIDTH-1:0] data_c;
  logic             ack_a;
  logic             ack_b;
  logic             ack_c;
  logic             z_valid;
  logic             z_ready;
  logic [WIDTH-1:0] z_data;
  logic [1:0]       z_src;

  modport master (
    output req_a, req_b, req_c,
    output data_a, data_b, data_c,
    output z_ready,
    input  ack_a, ack_b, ack_c,
    input  z_valid, z_data, z_src
  );

  modport slave (
    input  req_a, req_b, req_c,
    input  data_a, data_b, data_c,
    input  z_ready,
    output ack_a, ack_b, ack_c,
    output z_valid, z_data, z_src
  );

endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__aoi222_mux.sv
// One-hot three-way AND-OR select (aoi222 datapath); purely combinational.
// INV_OUT=1 gives the native inverting aoi222 polarity.
module gf180mcu_fd_sc_mcu9t5v0__aoi222_mux #(
  parameter int WIDTH   = 8,
  parameter bit INV_OUT = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [2:0]       sel,
  output logic [WIDTH-1:0] z
);

  logic [WIDTH-1:0] ao;

  assign ao = (a & {WIDTH{sel[0]}})
            | (b & {WIDTH{sel[1]}})
            | (c & {WIDTH{sel[2]}});

  generate
    if (INV_OUT) begin : g_inv
      assign z = ~ao;
    end else begin : g_true
      assign z = ao;
    end
  endgenerate

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__rrarb3.sv
// Round-robin arbiter for three producers into a one-entry registered output slice.
// Beat appears one cycle after grant; grants stall while the slice is full and not drained.
module gf180mcu_fd_sc_mcu9t5v0__rrarb3
  import gf180mcu_fd_sc_mcu9t5v0__rrarb3_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter bit INV_OUT = 1'b0
) (
  input logic clk,
  input logic rst,
  gf180mcu_fd_sc_mcu9t5v0__rrarb3_if.slave bus
);

  state_t           state;
  logic [1:0]       last;
  logic [2:0]       req;
  logic [2:0]       gnt;
  logic             can_load;
  logic             xfer;
  logic [WIDTH-1:0] sel_data;
  logic             z_valid_q;
  logic [WIDTH-1:0] z_data_q;
  logic [1:0]       z_src_q;

  assign req      = {bus.req_c, bus.req_b, bus.req_a};
  assign can_load = (state == ST_EMPTY) || bus.z_ready;
  // Reset gates the grant so a beat offered during reset is never acked.
  assign gnt      = (can_load && !rst) ? rr_next(last, req) : 3'b000;
  assign xfer     = |gnt;

  assign bus.ack_a   = gnt[0];
  assign bus.ack_b   = gnt[1];
  assign bus.ack_c   = gnt[2];
  assign bus.z_valid = z_valid_q;
  assign bus.z_data  = z_data_q;
  assign bus.z_src   = z_src_q;

  gf180mcu_fd_sc_mcu9t5v0__aoi222_mux #(
    .WIDTH   (WIDTH),
    .INV_OUT (INV_OUT)
  ) u_mux (
    .a   (bus.data_a),
    .b   (bus.data_b),
    .c   (bus.data_c),
    .sel (gnt),
    .z   (sel_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      z_valid_q <= 1'b0;
      z_data_q  <= '0;
      z_src_q   <= SRC_NONE;
      last      <= SRC_C;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (xfer) begin
            state     <= ST_FULL;
            z_valid_q <= 1'b1;
            z_data_q  <= sel_data;
            z_src_q   <= gnt_src(gnt);
            last      <= gnt_src(gnt);
          end
        end
        ST_FULL: begin
          if (bus.z_ready) begin
            if (xfer) begin
              // Consumer drains the old beat on the same edge the new one lands.
              z_data_q <= sel_data;
              z_src_q  <= gnt_src(gnt);
              last     <= gnt_src(gnt);
            end else begin
              state     <= ST_EMPTY;
              z_valid_q <= 1'b0;
              z_src_q   <= SRC_NONE;
            end
          end
        end
        default: begin
          state     <= ST_EMPTY;
          z_valid_q <= 1'b0;
          z_src_q   <= SRC_NONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt) && ((gnt & req) == gnt));
    end
  end

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__rrarb3.sv
// Directed bench with a beat scoreboard: stimulus pushes expected beats, monitors pop on z handshake.
module tb_gf180mcu_fd_sc_mcu9t5v0__rrarb3;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] dat;
    logic [1:0]   src;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__rrarb3_if #(.WIDTH(W)) bus ();
  gf180mcu_fd_sc_mcu9t5v0__rrarb3_if #(.WIDTH(W)) ibus ();

  gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.WIDTH(W), .INV_OUT(1'b0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  gf180mcu_fd_sc_mcu9t5v0__rrarb3 #(.WIDTH(W), .INV_OUT(1'b1)) u_inv (
    .clk (clk),
    .rst (rst),
    .bus (ibus)
  );

  beat_t        exp_q[$];
  beat_t        inv_q[$];
  int           nvec  = 0;
  int           nfail = 0;
  logic [W-1:0] da, db, dc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // One bus cycle: drive after the edge, check the combinational grant mid-cycle.
  task automatic cyc(input logic r, input logic [2:0] req, input logic rdy,
                     input logic [2:0] exp_ack, input string name);
    @(posedge clk);
    #1;
    rst = r;
    bus.data_a = da;
    bus.data_b = db;
    bus.data_c = dc;
    {bus.req_c, bus.req_b, bus.req_a} = req;
    bus.z_ready = rdy;
    @(negedge clk);
    chk(name, {29'd0, bus.ack_c, bus.ack_b, bus.ack_a}, {29'd0, exp_ack});
    case (exp_ack)
      3'b001:  exp_q.push_back(beat_t'{dat: da, src: 2'd0});
      3'b010:  exp_q.push_back(beat_t'{dat: db, src: 2'd1});
      3'b100:  exp_q.push_back(beat_t'{dat: dc, src: 2'd2});
      default: ;
    endcase
  endtask

  initial begin : mon_main
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.z_valid && bus.z_ready) begin
        if (exp_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_beat: got data %0h src %0d, required no beat", bus.z_data, bus.z_src);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {24'd0, bus.z_data}, {24'd0, e.dat});
          chk("beat_src", {30'd0, bus.z_src}, {30'd0, e.src});
        end
      end
    end
  end

  initial begin : mon_inv
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst && ibus.z_valid && ibus.z_ready) begin
        if (inv_q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL inv_unexpected_beat: got data %0h src %0d, required no beat", ibus.z_data, ibus.z_src);
        end else begin
          e = inv_q.pop_front();
          chk("inv_beat_data", {24'd0, ibus.z_data}, {24'd0, e.dat});
          chk("inv_beat_src", {30'd0, ibus.z_src}, {30'd0, e.src});
        end
      end
    end
  end

  initial begin
    da = '0; db = '0; dc = '0;
    {bus.req_a, bus.req_b, bus.req_c} = 3'b000;
    bus.data_a = '0; bus.data_b = '0; bus.data_c = '0;
    bus.z_ready = 1'b0;
    {ibus.req_a, ibus.req_b, ibus.req_c} = 3'b000;
    ibus.data_a = '0; ibus.data_b = '0; ibus.data_c = '0;
    ibus.z_ready = 1'b0;

    // Reset state
    cyc(1'b1, 3'b000, 1'b0, 3'b000, "rst_ack0");
    cyc(1'b1, 3'b111, 1'b1, 3'b000, "rst_ack_blocked");
    chk("rst_valid", {31'd0, bus.z_valid}, 32'd0);
    chk("rst_src", {30'd0, bus.z_src}, 32'd3);
    chk("rst_data", {24'd0, bus.z_data}, 32'd0);

    // Single beat from A, then idle drains to EMPTY
    da = 8'h5A;
    cyc(1'b0, 3'b001, 1'b1, 3'b001, "t1_ack_a");
    cyc(1'b0, 3'b000, 1'b1, 3'b000, "t1_idle_ack");
    chk("t1_valid", {31'd0, bus.z_valid}, 32'd1);
    cyc(1'b0, 3'b000, 1'b1, 3'b000, "t1_idle2_ack");
    chk("t1_empty_valid", {31'd0, bus.z_valid}, 32'd0);
    chk("t1_empty_src", {30'd0, bus.z_src}, 32'd3);

    // All three requesting: A,B,C,A,B,C back-to-back
    cyc(1'b1, 3'b000, 1'b0, 3'b000, "t2_rst");
    da = 8'h11; db = 8'h22; dc = 8'h33;
    cyc(1'b0, 3'b111, 1'b1, 3'b001, "t2_g1_a");
    cyc(1'b0, 3'b111, 1'b1, 3'b010, "t2_g2_b");
    chk("t2_full", {31'd0, bus.z_valid}, 32'd1);
    cyc(1'b0, 3'b111, 1'b1, 3'b100, "t2_g3_c");
    cyc(1'b0, 3'b111, 1'b1, 3'b001, "t2_g4_a");
    cyc(1'b0, 3'b110, 1'b1, 3'b010, "t2_g5_b");
    cyc(1'b0, 3'b100, 1'b1, 3'b100, "t2_g6_c");
    cyc(1'b0, 3'b000, 1'b1, 3'b000, "t2_drain");
    chk("t2_no_backlog", exp_q.size(), 32'd0);

    // Backpressure: B waits while the slice is full and not drained
    cyc(1'b0, 3'b010, 1'b1, 3'b010, "t3_load_b");
    db = 8'h44;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 3'b010, 1'b0, 3'b000, "t3_stall_ack");
      chk("t3_hold_data", {24'd0, bus.z_data}, 32'h22);
    end
    cyc(1'b0, 3'b010, 1'b1, 3'b010, "t3_resume_b");
    cyc(1'b0, 3'b000, 1'b1, 3'b000, "t3_drain");

    // Reset while FULL with A requesting: held beat discarded, A leads afterward
    da = 8'h77;
    cyc(1'b0, 3'b001, 1'b1, 3'b001, "t5_load_a");
    cyc(1'b1, 3'b001, 1'b0, 3'b000, "t5_ack_in_rst");
    chk("t5_held_pending", exp_q.size(), 32'd1);
    exp_q.delete();
    db = 8'h22; dc = 8'h33;
    cyc(1'b0, 3'b111, 1'b1, 3'b001, "t5_first_after_rst");
    chk("t5_valid", {31'd0, bus.z_valid}, 32'd0);
    chk("t5_src", {30'd0, bus.z_src}, 32'd3);
    chk("t5_data", {24'd0, bus.z_data}, 32'd0);
    cyc(1'b0, 3'b110, 1'b1, 3'b010, "t5_then_b");
    cyc(1'b0, 3'b100, 1'b1, 3'b100, "t5_then_c");
    cyc(1'b0, 3'b000, 1'b1, 3'b000, "t5_drain");

    // LAST follows the actual grant: C alone, then A+C
    da = 8'hA5; dc = 8'h3C;
    cyc(1'b0, 3'b100, 1'b1, 3'b100, "t6_c_only");
    cyc(1'b0, 3'b101, 1'b1, 3'b001, "t6_ac_a");
    cyc(1'b0, 3'b101, 1'b1, 3'b100, "t6_ac_c");
    cyc(1'b0, 3'b001, 1'b1, 3'b001, "t6_a");
    cyc(1'b0, 3'b000, 1'b1, 3'b000, "t6_drain");

    // Inverted-polarity instance
    @(posedge clk);
    #1;
    ibus.data_c = 8'h0F;
    ibus.req_c  = 1'b1;
    ibus.z_ready = 1'b1;
    @(negedge clk);
    chk("inv_ack", {29'd0, ibus.ack_c, ibus.ack_b, ibus.ack_a}, 32'b100);
    inv_q.push_back(beat_t'{dat: 8'hF0, src: 2'd2});
    @(posedge clk);
    #1;
    ibus.req_c = 1'b0;
    @(negedge clk);
    chk("inv_valid", {31'd0, ibus.z_valid}, 32'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("main_queue_drained", exp_q.size(), 32'd0);
    chk("inv_queue_drained", inv_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
